// File: rtl/idct_1d_pkg.sv
// idct_1d_pkg: shared constants, FSM encoding and cosine-weight lookup for the 16-point IDCT.
package idct_1d_pkg;
    localparam int N         = 16;
    localparam int SHIFT_DEF = 9;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // idx selects C_idx from the constant bus; idx 0 stands for a zero weight
    typedef struct packed {
        logic       neg;
        logic [5:0] idx;
    } wsel_t;

    function automatic wsel_t weight_sel(input logic [2:0] n, input logic [3:0] k);
        logic [5:0] m, f, r;
        wsel_t      w;
        m     = {2'b00, n, 1'b1} * {2'b00, k};
        f     = (m > 6'd32) ? -m : m;
        r     = 6'd32 - f;
        w.idx = (k == 4'd0) ? 6'd8 : (f < 6'd16) ? f : (f == 6'd16) ? 6'd0 : r;
        w.neg = (k != 4'd0) && (f > 6'd16);
        return w;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        return (v > 127) ? 8'h7f : (v < -128) ? 8'h80 : v[7:0];
    endfunction
endpackage

// File: rtl/idct_mac8.sv
// idct_mac8: 8-term signed dot product; each weight is a constant magnitude plus a subtract flag.
module idct_mac8 #(
    parameter int BW  = 11,
    parameter int C_W = 7,
    parameter int AW  = 22
) (
    input  logic [8*BW-1:0]      x_i,
    input  logic [8*C_W-1:0]     c_i,
    input  logic [7:0]           neg_i,
    output logic signed [AW-1:0] acc_o
);
    localparam int PW = BW + C_W;

    logic signed [PW-1:0] prod [8];

    for (genvar i = 0; i < 8; i++) begin : g_prod
        assign prod[i] = PW'($signed(x_i[i*BW +: BW])) * PW'($signed(c_i[i*C_W +: C_W]));
    end

    // negating the product rather than the constant keeps -C representable
    always_comb begin
        acc_o = '0;
        for (int j = 0; j < 8; j++)
            acc_o = neg_i[j] ? acc_o - AW'(prod[j]) : acc_o + AW'(prod[j]);
    end
endmodule

// File: rtl/idct_1d.sv
// idct_1d: 16-point 1-D IDCT producing the mirrored pair x[n], x[15-n] each cycle
// from an even-part and an odd-part MAC sharing the same weight lookup.
module idct_1d
    import idct_1d_pkg::*;
#(
    parameter int BW    = 11,
    parameter int C_W   = 7,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*BW-1:0]  X_k_in,
    input  logic [N*C_W-1:0] c_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [8*N-1:0]   x_n_out,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = BW + C_W + 4;

    state_t               state_q, state_d;
    logic [2:0]           n_q;
    logic [N*BW-1:0]      x_q;
    logic [N*C_W-1:0]     c_q;
    logic [8*N-1:0]       out_q;
    logic [(N+1)*C_W-1:0] cz;
    logic [8*BW-1:0]      xe, xo;
    logic [8*C_W-1:0]     ce, co;
    logic [7:0]           neg_e, neg_o;
    wsel_t                we, wo;
    logic signed [AW-1:0] e_acc, o_acc;
    logic signed [AW:0]   s_sum, s_dif;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? CALC : IDLE;
            CALC:    state_d = (n_q == 3'd7) ? DONE : CALC;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // slot 0 of cz is a zero constant so index 0 yields a zero weight
    assign cz = {c_q, {C_W{1'b0}}};

    always_comb begin
        xe    = '0;
        xo    = '0;
        ce    = '0;
        co    = '0;
        neg_e = '0;
        neg_o = '0;
        we    = '0;
        wo    = '0;
        for (int i = 0; i < 8; i++) begin
            we                = weight_sel(n_q, 4'(2 * i));
            wo                = weight_sel(n_q, 4'(2 * i + 1));
            xe[i*BW +: BW]    = x_q[2*i*BW +: BW];
            xo[i*BW +: BW]    = x_q[(2*i+1)*BW +: BW];
            ce[i*C_W +: C_W]  = cz[we.idx*C_W +: C_W];
            co[i*C_W +: C_W]  = cz[wo.idx*C_W +: C_W];
            neg_e[i]          = we.neg;
            neg_o[i]          = wo.neg;
        end
    end

    idct_mac8 #(.BW(BW), .C_W(C_W), .AW(AW)) u_even (
        .x_i(xe), .c_i(ce), .neg_i(neg_e), .acc_o(e_acc)
    );

    idct_mac8 #(.BW(BW), .C_W(C_W), .AW(AW)) u_odd (
        .x_i(xo), .c_i(co), .neg_i(neg_o), .acc_o(o_acc)
    );

    assign s_sum = (AW+1)'(e_acc) + (AW+1)'(o_acc);
    assign s_dif = (AW+1)'(e_acc) - (AW+1)'(o_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            out_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            x_q <= X_k_in;
            c_q <= c_in;
            n_q <= '0;
        end else if (state_q == CALC) begin
            out_q[n_q*8 +: 8]      <= sat8(32'(s_sum >>> SHIFT));
            out_q[(15-n_q)*8 +: 8] <= sat8(32'(s_dif >>> SHIFT));
            n_q                    <= n_q + 3'd1;
        end
    end

    assign x_n_out = out_q;
endmodule

// File: tb/tb_idct_1d.sv
// tb_idct_1d: scoreboard bench for idct_1d; the model evaluates every output directly
// from the cosine-index rule, without the even/odd split used by the design.
module tb_idct_1d;
    localparam int BW = 11;
    localparam int C_W = 7;
    localparam int SH = 9;
    // C_1 = round(63.69) = 64 does not fit a signed 7-bit constant, so it is clamped to 63
    localparam int CT [16] = '{63, 63, 61, 59, 56, 53, 49, 45, 41, 36, 30, 24, 19, 12, 6, 0};

    typedef struct {
        logic [127:0] v;
        logic         ends;
        logic [7:0]   e0;
        logic [7:0]   e15;
    } exp_t;

    logic              clk = 0;
    logic              rst = 1;
    logic [16*BW-1:0]  X_k_in = '0;
    logic [16*C_W-1:0] c_in = '0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [127:0]      x_n_out;
    logic              out_valid;
    logic              out_ready = 0;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                bp_mode = 1;
    exp_t              sbq[$];
    exp_t              me;

    idct_1d #(.BW(BW), .C_W(C_W), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst), .X_k_in(X_k_in), .c_in(c_in), .in_valid(in_valid),
        .in_ready(in_ready), .x_n_out(x_n_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 0: stall, 1: always ready, 2: random back-pressure
    always @(posedge clk) begin
        #1;
        out_ready = (bp_mode == 1) ? 1'b1 : (bp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int cval(input logic [16*C_W-1:0] cv, input int j);
        return int'($signed(cv[(j-1)*C_W +: C_W]));
    endfunction

    function automatic logic [127:0] model(input logic [16*BW-1:0] xv, input logic [16*C_W-1:0] cv);
        logic [127:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            int s;
            s = 0;
            for (int k = 0; k < 16; k++) begin
                int m, w;
                m = ((2 * n + 1) * k) % 64;
                if (m > 32) m = 64 - m;
                if (k == 0) w = cval(cv, 8);
                else if (m < 16) w = cval(cv, m);
                else if (m == 16) w = 0;
                else w = -cval(cv, 32 - m);
                s += w * int'($signed(xv[k*BW +: BW]));
            end
            s = s >>> SH;
            r[n*8 +: 8] = 8'((s > 127) ? 127 : (s < -128) ? -128 : s);
        end
        return r;
    endfunction

    function automatic logic [16*C_W-1:0] std_c();
        logic [16*C_W-1:0] r;
        for (int j = 0; j < 16; j++) r[j*C_W +: C_W] = C_W'(CT[j]);
        return r;
    endfunction

    function automatic logic [16*BW-1:0] xvec(input int x0, input int x1);
        logic [16*BW-1:0] r;
        r = '0;
        r[0 +: BW] = BW'(x0);
        r[BW +: BW] = BW'(x1);
        return r;
    endfunction

    function automatic logic [16*BW-1:0] rand_x();
        logic [16*BW-1:0] r;
        for (int k = 0; k < 16; k++) r[k*BW +: BW] = BW'($urandom_range(0, 2047));
        return r;
    endfunction

    // called at a negedge; the vector is captured at the following posedge
    task automatic send(input logic [16*BW-1:0] xv, input logic [16*C_W-1:0] cv,
                        input exp_t e, input bit push, output int cap);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'd1);
        X_k_in = xv;
        c_in = cv;
        in_valid = 1;
        if (push) sbq.push_back(e);
        @(negedge clk);
        cap = cyc;
        in_valid = 0;
    endtask

    task automatic drain(input int lim);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 128'(sbq.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", x_n_out);
            end else begin
                me = sbq.pop_front();
                chk("vector", x_n_out, me.v);
                if (me.ends) begin
                    chk("x0", 128'(x_n_out[7:0]), 128'(me.e0));
                    chk("x15", 128'(x_n_out[127:120]), 128'(me.e15));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [16*BW-1:0]  xv;
        logic [16*C_W-1:0] cv;
        logic [127:0]      ev;
        int                lat, ca, cb, t, seen;
        exp_t              e;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_x_n_out", x_n_out, 128'd0);

        // DC input 256: 256*45 >>> 9 = 22 everywhere; captured on the first edge after reset
        rst = 0;
        e = '{v: {16{8'd22}}, ends: 0, e0: 0, e15: 0};
        send(xvec(256, 0), std_c(), e, 1, ca);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat), 128'd9);

        // -1024*45 >>> 9 = -90 exactly; then the saturating pair, back to back
        e = '{v: {16{8'ha6}}, ends: 0, e0: 0, e15: 0};
        send(xvec(-1024, 0), std_c(), e, 1, ca);
        e = '{v: model(xvec(1023, 1023), std_c()), ends: 1, e0: 8'd127, e15: 8'hdc};
        send(xvec(1023, 1023), std_c(), e, 1, cb);
        chk("throughput", 128'(cb - ca), 128'd10);
        drain(100);

        // stall in DONE while a second vector is offered
        bp_mode = 0;
        repeat (2) @(negedge clk);
        xv = rand_x();
        ev = model(xv, std_c());
        e = '{v: ev, ends: 0, e0: 0, e15: 0};
        send(xv, std_c(), e, 1, ca);
        t = 0;
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("stall_out_valid", 128'(out_valid), 128'd1);
        X_k_in = rand_x();
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", x_n_out, ev);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 0;
        bp_mode = 1;
        drain(20);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("no_second_capture", 128'(seen), 128'd0);

        // abort in the n=4 CALC cycle
        send(rand_x(), std_c(), e, 0, ca);
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_in_ready", 128'(in_ready), 128'd1);
        chk("abort_out_valid", 128'(out_valid), 128'd0);
        chk("abort_x_n_out", x_n_out, 128'd0);
        rst = 0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_output", 128'(seen), 128'd0);
        xv = rand_x();
        e = '{v: model(xv, std_c()), ends: 0, e0: 0, e15: 0};
        send(xv, std_c(), e, 1, ca);
        drain(30);

        // random vectors, half with random constants, under random back-pressure
        bp_mode = 2;
        for (int i = 0; i < 100; i++) begin
            xv = rand_x();
            cv = std_c();
            if (i % 2 == 1)
                for (int j = 0; j < 16; j++) cv[j*C_W +: C_W] = C_W'($urandom_range(0, 127));
            e = '{v: model(xv, cv), ends: 0, e0: 0, e15: 0};
            send(xv, cv, e, 1, ca);
        end
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
